// File: rtl/timer_ctrl_if.sv
// CPU-side register port of timer_ctrl: write strobe, address, data,
// combinational read data, and the level interrupt with its acknowledge.
interface timer_ctrl_if;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       irq;
    logic       irq_ack;

    modport master (
        output we,
        output addr,
        output wdata,
        output irq_ack,
        input  rdata,
        input  irq
    );

    modport slave (
        input  we,
        input  addr,
        input  wdata,
        input  irq_ack,
        output rdata,
        output irq
    );
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl: turns CPU register writes into the enable/set/count protocol of
// one timer, acknowledges each timer done, keeps sticky status flags and
// raises a level interrupt.
module timer_ctrl (
    input  logic              clk,
    input  logic              rst,
    timer_ctrl_if.slave       bus,
    output logic              tmr_enable,
    output logic              tmr_set,
    output logic              tmr_direction,
    output logic              tmr_auto_reload,
    output logic              tmr_done_ack,
    output logic [15:0]       tmr_count,
    input  logic              tmr_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_PAUSED = 2'd3
    } state_t;

    state_t      state_r, state_nx;
    logic [7:0]  count_lo_r, count_lo_nx;
    logic [7:0]  count_hi_r, count_hi_nx;
    logic        dir_r, dir_nx;
    logic        auto_r, auto_nx;
    logic        irq_en_r, irq_en_nx;
    logic        pause_r, pause_nx;
    logic        done_r, done_nx;
    logic        irq_pend_r, irq_pend_nx;
    logic        overrun_r, overrun_nx;
    logic        done_ack_r;
    logic        enable_r;
    logic        set_r;
    logic        irq_r;

    logic        ctrl_wr_s, status_wr_s, start_s, stop_s, event_s, pend_clr_s;
    logic        running_s;

    assign ctrl_wr_s   = bus.we && (bus.addr == 2'd2);
    assign status_wr_s = bus.we && (bus.addr == 2'd3);
    assign start_s     = ctrl_wr_s && bus.wdata[0];
    assign stop_s      = ctrl_wr_s && bus.wdata[4];
    // The ack cycle masks a done that is still high, so one assertion is one event.
    assign event_s     = tmr_done && !done_ack_r;
    assign pend_clr_s  = bus.irq_ack || (status_wr_s && bus.wdata[2]);
    assign running_s   = (state_r != ST_IDLE);

    assign tmr_enable      = enable_r;
    assign tmr_set         = set_r;
    assign tmr_done_ack    = done_ack_r;
    assign tmr_count       = {count_hi_r, count_lo_r};
    assign tmr_direction   = dir_r;
    assign tmr_auto_reload = auto_r;
    assign bus.irq         = irq_r;

    // Next values of the CPU-visible registers and sticky flags.
    always_comb begin
        count_lo_nx = count_lo_r;
        count_hi_nx = count_hi_r;
        dir_nx      = dir_r;
        auto_nx     = auto_r;
        irq_en_nx   = irq_en_r;
        pause_nx    = pause_r;
        if (bus.we && (bus.addr == 2'd0)) begin
            count_lo_nx = bus.wdata;
        end else if (bus.we && (bus.addr == 2'd1)) begin
            count_hi_nx = bus.wdata;
        end else if (ctrl_wr_s) begin
            dir_nx    = bus.wdata[1];
            auto_nx   = bus.wdata[2];
            irq_en_nx = bus.wdata[3];
            pause_nx  = bus.wdata[5];
        end else begin
            count_lo_nx = count_lo_r;
        end

        // A new event beats any clear arriving in the same cycle.
        if (event_s) begin
            done_nx = 1'b1;
        end else if (status_wr_s && bus.wdata[1]) begin
            done_nx = 1'b0;
        end else begin
            done_nx = done_r;
        end

        if (event_s && irq_en_r) begin
            irq_pend_nx = 1'b1;
        end else if (pend_clr_s) begin
            irq_pend_nx = 1'b0;
        end else begin
            irq_pend_nx = irq_pend_r;
        end

        // A coincident acknowledge consumes the old request, so no overrun then.
        if (event_s && irq_en_r && irq_pend_r && !pend_clr_s) begin
            overrun_nx = 1'b1;
        end else if (status_wr_s && bus.wdata[3]) begin
            overrun_nx = 1'b0;
        end else begin
            overrun_nx = overrun_r;
        end
    end

    // Sequencer next state; PAUSE takes effect in the cycle it is written.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s && !stop_s) state_nx = ST_LOAD;
                else                    state_nx = ST_IDLE;
            end
            ST_LOAD: begin
                if (stop_s)        state_nx = ST_IDLE;
                else if (start_s)  state_nx = ST_LOAD;
                else if (pause_nx) state_nx = ST_PAUSED;
                else               state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (stop_s)                  state_nx = ST_IDLE;
                else if (start_s)            state_nx = ST_LOAD;
                else if (event_s && !auto_r) state_nx = ST_IDLE;
                else if (pause_nx)           state_nx = ST_PAUSED;
                else                         state_nx = ST_RUN;
            end
            ST_PAUSED: begin
                if (stop_s)         state_nx = ST_IDLE;
                else if (start_s)   state_nx = ST_LOAD;
                else if (!pause_nx) state_nx = ST_RUN;
                else                state_nx = ST_PAUSED;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, registers and registered timer/interrupt outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            count_lo_r <= 8'd0;
            count_hi_r <= 8'd0;
            dir_r      <= 1'b0;
            auto_r     <= 1'b0;
            irq_en_r   <= 1'b0;
            pause_r    <= 1'b0;
            done_r     <= 1'b0;
            irq_pend_r <= 1'b0;
            overrun_r  <= 1'b0;
            done_ack_r <= 1'b0;
            enable_r   <= 1'b0;
            set_r      <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            state_r    <= state_nx;
            count_lo_r <= count_lo_nx;
            count_hi_r <= count_hi_nx;
            dir_r      <= dir_nx;
            auto_r     <= auto_nx;
            irq_en_r   <= irq_en_nx;
            pause_r    <= pause_nx;
            done_r     <= done_nx;
            irq_pend_r <= irq_pend_nx;
            overrun_r  <= overrun_nx;
            done_ack_r <= event_s;
            enable_r   <= (state_nx == ST_LOAD) || (state_nx == ST_RUN);
            set_r      <= (state_nx == ST_LOAD);
            irq_r      <= irq_pend_nx && irq_en_nx;
        end
    end

    // Combinational register read-back.
    always_comb begin
        bus.rdata = 8'd0;
        case (bus.addr)
            2'd0:    bus.rdata = count_lo_r;
            2'd1:    bus.rdata = count_hi_r;
            2'd2:    bus.rdata = {2'b00, pause_r, 1'b0, irq_en_r, auto_r, dir_r, 1'b0};
            2'd3:    bus.rdata = {4'b0000, overrun_r, irq_pend_r, done_r, running_s};
            default: bus.rdata = 8'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: the bench plays both the CPU and the timer's
// done line. Inputs change on the falling edge, outputs are checked there too.
module tb_timer_ctrl;

    logic        clk;
    logic        rst;
    logic        tmr_enable, tmr_set, tmr_direction, tmr_auto_reload, tmr_done_ack;
    logic [15:0] tmr_count;
    logic        tmr_done;
    int          total;
    int          bad;

    timer_ctrl_if bus ();

    timer_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .tmr_enable      (tmr_enable),
        .tmr_set         (tmr_set),
        .tmr_direction   (tmr_direction),
        .tmr_auto_reload (tmr_auto_reload),
        .tmr_done_ack    (tmr_done_ack),
        .tmr_count       (tmr_count),
        .tmr_done        (tmr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One register write, sampled on the rising edge between two falling edges.
    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        @(negedge clk);
        bus.we = 1'b0; bus.addr = 2'd3; bus.wdata = 8'd0;
    endtask

    task automatic status(input string tag, input logic [7:0] exp);
        bus.addr = 2'd3;
        #1;
        check(tag, {8'd0, bus.rdata}, {8'd0, exp});
    endtask

    // Timer done held two cycles: seen, then masked during the ack cycle.
    task automatic done_pulse();
        @(negedge clk); tmr_done = 1'b1;
        @(negedge clk);
        check("ack_pulse", {15'd0, tmr_done_ack}, 16'd1);
        @(negedge clk); tmr_done = 1'b0;
        check("ack_single", {15'd0, tmr_done_ack}, 16'd0);
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; tmr_done = 1'b0;
        bus.we = 1'b0; bus.addr = 2'd3; bus.wdata = 8'd0; bus.irq_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_enable", {15'd0, tmr_enable}, 16'd0);
        check("rst_set", {15'd0, tmr_set}, 16'd0);
        check("rst_count", tmr_count, 16'h0000);
        check("rst_irq", {15'd0, bus.irq}, 16'd0);
        status("rst_status", 8'h00);
        rst = 1'b0;

        // One-shot down count of 3.
        wr(2'd0, 8'h03);
        wr(2'd1, 8'h00);
        bus.addr = 2'd0; #1;
        check("lo_readback", {8'd0, bus.rdata}, 16'h0003);
        wr(2'd2, 8'h01);
        check("load_set", {15'd0, tmr_set}, 16'd1);
        check("load_enable", {15'd0, tmr_enable}, 16'd1);
        check("load_count", tmr_count, 16'h0003);
        check("load_dir", {15'd0, tmr_direction}, 16'd0);
        @(negedge clk);
        check("run_set", {15'd0, tmr_set}, 16'd0);
        check("run_enable", {15'd0, tmr_enable}, 16'd1);
        status("run_status", 8'h01);
        done_pulse();
        check("oneshot_idle", {15'd0, tmr_enable}, 16'd0);
        check("oneshot_irq", {15'd0, bus.irq}, 16'd0);
        status("oneshot_status", 8'h02);
        wr(2'd3, 8'h02);
        status("done_clear", 8'h00);

        // Auto-reload up count with interrupts, two events without acknowledge.
        wr(2'd0, 8'h05);
        wr(2'd2, 8'h0F);
        check("auto_count", tmr_count, 16'h0005);
        check("auto_dir", {15'd0, tmr_direction}, 16'd1);
        check("auto_reload", {15'd0, tmr_auto_reload}, 16'd1);
        bus.addr = 2'd2; #1;
        check("ctrl_readback", {8'd0, bus.rdata}, 16'h000E);
        @(negedge clk);
        @(negedge clk); tmr_done = 1'b1;
        @(negedge clk);
        check("irq_rise", {15'd0, bus.irq}, 16'd1);
        check("auto_keeps_run", {15'd0, tmr_enable}, 16'd1);
        status("masked_no_overrun", 8'h07);
        @(negedge clk); tmr_done = 1'b0;
        repeat (3) @(negedge clk);
        done_pulse();
        status("overrun_status", 8'h0F);
        wr(2'd3, 8'h0E);
        status("clear_flags", 8'h01);
        check("irq_cleared", {15'd0, bus.irq}, 16'd0);

        // Pause holds the timer disabled, resume re-enables without a reload.
        wr(2'd2, 8'h2E);
        for (int i = 0; i < 10; i++) begin
            check("paused_enable", {15'd0, tmr_enable}, 16'd0);
            @(negedge clk);
        end
        status("paused_running", 8'h01);
        wr(2'd2, 8'h0E);
        check("resume_enable", {15'd0, tmr_enable}, 16'd1);
        check("resume_no_set", {15'd0, tmr_set}, 16'd0);

        // START together with STOP: stop wins.
        wr(2'd2, 8'h11);
        check("stopwins_enable", {15'd0, tmr_enable}, 16'd0);
        check("stopwins_set", {15'd0, tmr_set}, 16'd0);
        status("stopwins_status", 8'h00);

        // Acknowledge coincident with a new event.
        wr(2'd2, 8'h0D);
        @(negedge clk);
        done_pulse();
        status("pend_set", 8'h07);
        tmr_done = 1'b1; bus.irq_ack = 1'b1;
        @(negedge clk);
        bus.irq_ack = 1'b0;
        check("coinc_irq", {15'd0, bus.irq}, 16'd1);
        status("coinc_status", 8'h07);
        @(negedge clk); tmr_done = 1'b0;
        bus.irq_ack = 1'b1;
        @(negedge clk); bus.irq_ack = 1'b0;
        status("ack_clears", 8'h03);
        check("ack_irq_low", {15'd0, bus.irq}, 16'd0);

        // Reset in the middle of running.
        #2 rst = 1'b1;
        #1;
        check("midrst_enable", {15'd0, tmr_enable}, 16'd0);
        check("midrst_count", tmr_count, 16'h0000);
        check("midrst_auto", {15'd0, tmr_auto_reload}, 16'd0);
        check("midrst_ack", {15'd0, tmr_done_ack}, 16'd0);
        status("midrst_status", 8'h00);
        @(negedge clk); rst = 1'b0;

        // Stale done while idle is still acknowledged and flagged.
        done_pulse();
        status("idle_event", 8'h02);
        check("idle_stays", {15'd0, tmr_enable}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Bus-facing controller that configures and sequences one `timer` instance for the 8-bit CPU. The CPU writes a 16-bit reload value and control bits over an 8-bit register port. The block converts these writes into the timer's `enable`/`set`/`count` protocol and acknowledges each timer `done`. It also maintains sticky status flags and raises an interrupt request to the CPU's interrupt logic.

## Interface
Parameters: none.

- `clk` in 1 — system clock; all state on rising edge
- `rst` in 1 — asynchronous, active-high reset
- `we` in 1 — register write strobe, sampled on `clk`
- `addr` in 2 — register select: 0 COUNT_LO, 1 COUNT_HI, 2 CTRL, 3 STATUS
- `wdata` in 8 — write data
- `rdata` out 8 — combinational read of register at `addr`
- `irq` out 1 — interrupt request, level
- `irq_ack` in 1 — CPU interrupt acknowledge, one-cycle pulse
- `tmr_enable` out 1 — to timer `enable`
- `tmr_set` out 1 — to timer `set`
- `tmr_direction` out 1 — to timer `direction`; 1 = up
- `tmr_auto_reload` out 1 — to timer `auto_reload`
- `tmr_done_ack` out 1 — to timer `done_ack`
- `tmr_count` out 16 — to timer `count`
- `tmr_done` in 1 — from timer `done`

## Operation
Registers:
- COUNT_LO/COUNT_HI: 16-bit shadow `{HI,LO}`, reads back as written. It is used only at the next start; writes while running do not affect the running timer.
- CTRL:
  - bit0 START and bit4 STOP are strobes and read as 0.
  - Stored bits: bit1 DIR, bit2 AUTO, bit3 IRQ_EN, bit5 PAUSE.
  - Bits 7:6 are ignored and read as 0.
- STATUS, read:
  - bit0 RUNNING (state RUN or PAUSED, or LOAD)
  - bit1 DONE (sticky)
  - bit2 IRQ_PEND
  - bit3 OVERRUN (sticky)
  - others 0
- STATUS, write: writing 1 to bit1, bit2 or bit3 clears that flag.

FSM states IDLE, LOAD, RUN, PAUSED:
- IDLE: `tmr_enable`=0. CTRL write with START=1, STOP=0 → LOAD.
- LOAD, one cycle: `tmr_enable`=1, `tmr_set`=1, `tmr_count`=shadow, `tmr_direction`=DIR, `tmr_auto_reload`=AUTO. Next state is PAUSED if PAUSE=1, else RUN.
- RUN: `tmr_enable`=1.
  - PAUSE=1 → PAUSED.
  - STOP → IDLE.
  - START → LOAD (restart).
  - Timer event without AUTO → IDLE.
- PAUSED: `tmr_enable`=0, so the timer holds its count. PAUSE=0 → RUN. STOP/START behave as in RUN.
- STOP and START in the same write: STOP wins → IDLE.

Event handling:
- A timer event is `tmr_done`=1 while `tmr_done_ack`=0.
- On an event:
  - `tmr_done_ack` is registered high for exactly the next cycle.
  - DONE is set.
  - If IRQ_EN=1: if IRQ_PEND is already 1, OVERRUN is set; then IRQ_PEND is set.
- `irq` = IRQ_PEND & IRQ_EN.
- IRQ_PEND is cleared by `irq_ack` or by a STATUS bit2 write.

Output values:
- `tmr_count`, `tmr_direction` and `tmr_auto_reload` always drive shadow/DIR/AUTO.
- `tmr_set` is 1 only in LOAD.

## Timing
- Reset: state IDLE; all registers 0; `irq`, `tmr_enable`, `tmr_set`, `tmr_done_ack` = 0; `tmr_count` = 0.
- Start latency:
  - START write sampled at edge N.
  - LOAD during cycle N+1.
  - Timer counting from edge N+2.
- Ack latency: `tmr_done` seen high at edge N → `tmr_done_ack`=1 during cycle N+1. The timer's `done` is low from N+2.
  - `tmr_done` still high during the ack cycle is masked, so exactly one event is counted per done assertion.
- `irq` rises the cycle after the event edge.
- Simultaneous events:
  - Event and `irq_ack` (or STATUS clear) in the same cycle: the event wins; IRQ_PEND stays 1 and OVERRUN is not set.
  - Event and DONE clear in the same cycle: DONE stays 1.
- Events in LOAD or IDLE (e.g. stale `tmr_done`): still acked and flagged.
- Auto-reload with count < 2 may merge events; one event per observed `done` assertion is the defined behaviour.
- `rst` mid-operation returns all state to reset values immediately.

## Test plan
- Write LO=0x03, HI=0x00, CTRL=0x01 (down, no auto) → LOAD 1 cycle after the write. Then:
  - one `tmr_done` → `tmr_done_ack` 1-cycle pulse
  - STATUS=0x02
  - state IDLE
  - `irq`=0
- Count 0x0005, CTRL=0x0F (auto, IRQ_EN) → `irq`=1 one cycle after the first done. No `irq_ack` before the second done → STATUS=0x0F (bit0 RUNNING, DONE, IRQ_PEND, OVERRUN). STATUS write 0x0E → 0x01.
- Running, CTRL write with PAUSE=1 → `tmr_enable`=0 for 10 cycles, no done. PAUSE=0 → resumes with the remaining count.
- CTRL write 0x11 (START+STOP) while running → IDLE, `tmr_set` never asserted.
- `irq_ack` coincident with a new event → IRQ_PEND stays 1, OVERRUN=0.
- Assert `rst` during RUN → all outputs 0 immediately; STATUS=0x00.
